discus_imem: RTL and testbench

DISCUS_IMEM -- requirements
Module: discus_imem

---
 rtl/discus_imem.sv | 119 +++++++++++
 tb/tb_discus_imem.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/discus_imem.sv
// DISCUS instruction memory: 256x8 program RAM with a byte-stream loader and
// a small HALT/LOAD/RELEASE/RUN sequencer that holds the CPU in reset while loading.
module discus_imem (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] fetch_PC,
    input  logic       fetch_reset,
    output logic [7:0] fetch_instruction,
    output logic       cpu_reset,
    input  logic       load_start,
    input  logic [7:0] load_base,
    input  logic [7:0] load_count,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    output logic       load_ready,
    input  logic       halt,
    output logic       done
);

    localparam logic [1:0] ST_HALT    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_RUN     = 2'd3;

    localparam logic [7:0] NOP = 8'hc8;

    logic [1:0] state_q, state_d;
    logic [7:0] wptr_q, wptr_d;
    logic [8:0] cnt_q, cnt_d;
    logic [1:0] rel_q, rel_d;
    logic       done_q, done_d;
    logic [7:0] fetch_q, fetch_d;
    logic       accept;
    logic [8:0] cnt_init;

    logic [7:0] mem [0:255];

    assign cpu_reset         = (state_q != ST_RUN);
    assign load_ready        = (state_q == ST_LOAD);
    assign accept            = load_ready & load_valid;
    assign done              = done_q;
    assign fetch_instruction = fetch_q;
    // A zero count encodes a full 256-byte load.
    assign cnt_init          = (load_count == 8'd0) ? 9'd256 : {1'b0, load_count};

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        cnt_d   = cnt_q;
        rel_d   = rel_q;
        done_d  = 1'b0;
        fetch_d = (fetch_reset || cpu_reset) ? NOP : mem[fetch_PC];

        case (state_q)
            ST_HALT: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    wptr_d  = load_base;
                    cnt_d   = cnt_init;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    wptr_d = wptr_q + 8'd1;
                    cnt_d  = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) begin
                        state_d = ST_RELEASE;
                        rel_d   = 2'd0;
                    end
                end
                // Halt abandons the remainder; bytes already written stay put.
                if (halt) state_d = ST_HALT;
            end
            ST_RELEASE: begin
                if (halt) begin
                    state_d = ST_HALT;
                end else if (rel_q == 2'd2) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end else begin
                    rel_d = rel_q + 2'd1;
                end
            end
            default: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    wptr_d  = load_base;
                    cnt_d   = cnt_init;
                end else if (halt) begin
                    state_d = ST_HALT;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_HALT;
            wptr_q  <= 8'd0;
            cnt_q   <= 9'd0;
            rel_q   <= 2'd0;
            done_q  <= 1'b0;
            fetch_q <= NOP;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            cnt_q   <= cnt_d;
            rel_q   <= rel_d;
            done_q  <= done_d;
            fetch_q <= fetch_d;
        end
    end

    // RAM is deliberately outside the reset domain so a reset keeps the program.
    always_ff @(posedge clk) begin
        if (accept) mem[wptr_q] <= load_data;
    end

endmodule

// File: tb/tb_discus_imem.sv
// Directed + randomized bench for discus_imem with a byte-array memory model.
module tb_discus_imem;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] fetch_PC;
    logic       fetch_reset;
    logic [7:0] fetch_instruction;
    logic       cpu_reset;
    logic       load_start;
    logic [7:0] load_base;
    logic [7:0] load_count;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic       halt;
    logic       done;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] mem_m [256];
    logic [7:0] mptr;

    discus_imem dut (
        .clk(clk), .reset(reset), .fetch_PC(fetch_PC), .fetch_reset(fetch_reset),
        .fetch_instruction(fetch_instruction), .cpu_reset(cpu_reset),
        .load_start(load_start), .load_base(load_base), .load_count(load_count),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .halt(halt), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] b, input logic [7:0] c);
        load_base  = b;
        load_count = c;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        mptr = b;
        chk("enter_load_ready", {31'd0, load_ready}, 32'd1);
        chk("enter_load_cpurst", {31'd0, cpu_reset}, 32'd1);
    endtask

    task automatic feed_byte(input logic [7:0] d);
        chk("ready_before_byte", {31'd0, load_ready}, 32'd1);
        load_valid = 1'b1;
        load_data  = d;
        step();
        load_valid = 1'b0;
        mem_m[mptr] = d;
        mptr++;
    endtask

    // Random valid gaps; optional stray load_start pulses that must be ignored.
    task automatic feed_rand(input int n, input bit noise);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < 4000) begin
            chk("ready_in_load", {31'd0, load_ready}, 32'd1);
            load_valid = 1'($urandom_range(0, 1));
            load_data  = 8'($urandom);
            if (noise && $urandom_range(0, 3) == 0) begin
                load_start = 1'b1;
                load_base  = 8'($urandom);
                load_count = 8'($urandom);
            end
            step();
            load_start = 1'b0;
            if (load_valid) begin
                mem_m[mptr] = load_data;
                mptr++;
                got++;
            end
            cyc++;
        end
        load_valid = 1'b0;
        chk("load_budget", got, n);
    endtask

    task automatic release_chk();
        for (int i = 0; i < 3; i++) begin
            chk("rel_ready", {31'd0, load_ready}, 32'd0);
            chk("rel_cpurst", {31'd0, cpu_reset}, 32'd1);
            chk("rel_done", {31'd0, done}, 32'd0);
            step();
        end
        chk("run_cpurst", {31'd0, cpu_reset}, 32'd0);
        chk("run_ready", {31'd0, load_ready}, 32'd0);
        chk("done_pulse", {31'd0, done}, 32'd1);
        step();
        chk("done_once", {31'd0, done}, 32'd0);
    endtask

    task automatic do_load(input logic [7:0] b, input logic [7:0] c, input bit noise);
        pulse_start(b, c);
        feed_rand((c == 8'd0) ? 256 : int'(c), noise);
        release_chk();
    endtask

    task automatic fetch_chk(input logic [7:0] a);
        fetch_PC    = a;
        fetch_reset = 1'b0;
        step();
        chk($sformatf("fetch_%02h", a), {24'd0, fetch_instruction}, {24'd0, mem_m[a]});
    endtask

    initial begin
        reset = 1'b1; fetch_PC = 8'd0; fetch_reset = 1'b0; load_start = 1'b0;
        load_base = 8'd0; load_count = 8'd0; load_valid = 1'b0; load_data = 8'd0;
        halt = 1'b0;
        #2;
        chk("rst_cpurst", {31'd0, cpu_reset}, 32'd1);
        chk("rst_ready", {31'd0, load_ready}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_fetch", {24'd0, fetch_instruction}, 32'hc8);
        step();
        step();
        reset = 1'b0;
        step();
        chk("halt_cpurst", {31'd0, cpu_reset}, 32'd1);
        chk("halt_ready", {31'd0, load_ready}, 32'd0);
        chk("halt_fetch_nop", {24'd0, fetch_instruction}, 32'hc8);

        // Basic load with a valid gap and a stray load_start mid-load.
        pulse_start(8'h10, 8'd3);
        feed_byte(8'h11);
        chk("gap_ready", {31'd0, load_ready}, 32'd1);
        load_start = 1'b1; load_base = 8'h70; load_count = 8'd1;
        step();
        load_start = 1'b0;
        feed_byte(8'h22);
        feed_byte(8'h33);
        release_chk();
        fetch_chk(8'h10);
        fetch_chk(8'h11);
        chk("fetch_11_lit", {24'd0, fetch_instruction}, 32'h22);
        fetch_chk(8'h12);
        fetch_reset = 1'b1;
        fetch_PC    = 8'h11;
        step();
        fetch_reset = 1'b0;
        chk("fetch_reset_nop", {24'd0, fetch_instruction}, 32'hc8);
        fetch_chk(8'h11);

        // Halt from RUN; fetch returns NOP while the CPU is held.
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("halt_run_cpurst", {31'd0, cpu_reset}, 32'd1);
        chk("halt_run_ready", {31'd0, load_ready}, 32'd0);
        step();
        chk("halt_run_fetch", {24'd0, fetch_instruction}, 32'hc8);

        // Pointer wrap.
        do_load(8'hFE, 8'd4, 1'b0);
        fetch_chk(8'hFE);
        fetch_chk(8'hFF);
        fetch_chk(8'h00);
        fetch_chk(8'h01);

        // load_start beats halt in RUN; then a full 256-byte load.
        halt = 1'b1;
        pulse_start(8'($urandom), 8'd0);
        halt = 1'b0;
        feed_rand(256, 1'b1);
        release_chk();
        for (int i = 0; i < 8; i++) fetch_chk(8'($urandom));

        // Reset mid-load keeps written bytes and cancels the load.
        pulse_start(8'h40, 8'd5);
        feed_byte(8'hA1);
        feed_byte(8'hB2);
        #2 reset = 1'b1;
        #1;
        chk("midrst_cpurst", {31'd0, cpu_reset}, 32'd1);
        chk("midrst_ready", {31'd0, load_ready}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_fetch", {24'd0, fetch_instruction}, 32'hc8);
        step();
        reset = 1'b0;
        step();
        chk("postrst_ready", {31'd0, load_ready}, 32'd0);
        chk("postrst_cpurst", {31'd0, cpu_reset}, 32'd1);
        do_load(8'h80, 8'd5, 1'b1);
        fetch_chk(8'h40);
        fetch_chk(8'h41);
        for (int i = 0; i < 5; i++) fetch_chk(8'(8'h80 + i));

        // Halt during LOAD discards the rest.
        pulse_start(8'h20, 8'd4);
        feed_byte(8'h5A);
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("halt_load_ready", {31'd0, load_ready}, 32'd0);
        chk("halt_load_cpurst", {31'd0, cpu_reset}, 32'd1);
        step();
        chk("halt_load_stay", {31'd0, load_ready}, 32'd0);
        do_load(8'hC0, 8'd2, 1'b0);
        fetch_chk(8'h20);
        fetch_chk(8'hC0);
        fetch_chk(8'hC1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
